maxpool_engine: RTL
===================

# maxpool_engine

Parametrised 2x2 stride-2 max-pooling engine for the CNN datapath, the multi-channel successor to the single-map `maxp` block. It reads `channels` feature maps of side `matrix` from pixel memory, stored back to back starting at `memstartp`. It writes pooled maps of side `matrix>>1` contiguously starting at `memstartzap`, then raises `STOP`. The memory handshake is unchanged from `maxp`: registered `re`/`we`, and read data on `qp` one cycle after `re`.

## Interface
- `DATA_W`, 11: pixel width; data is two's-complement signed.
- `ADDR_W`, 13: pixel memory address width.
- `SIDE_W`, 5: width of `matrix` (map side).
- `SQ_W`, 10: width of `matrix2` (map area, `matrix*matrix`).
- `CH_W`, 4: width of `channels`.

- `clk`, in, 1: clock; all logic on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `maxp_en`, in, 1: start/run level. Deasserting it aborts or releases the engine.
- `memstartp`, in, ADDR_W: input base address.
- `memstartzap`, in, ADDR_W: output base address.
- `matrix`, in, SIDE_W: input map side.
- `matrix2`, in, SQ_W: input map area; this is the per-channel address stride.
- `channels`, in, CH_W: number of maps to pool.
- `read_addressp`, out, ADDR_W: read address.
- `re`, out, 1: read strobe.
- `qp`, in, DATA_W: read data, valid one cycle after `re`.
- `write_addressp`, out, ADDR_W: write address.
- `we`, out, 1: write strobe.
- `dp`, out, DATA_W signed: write data.
- `STOP`, out, 1: completion flag.

## Operation
- The FSM states are IDLE, RD0, RD1, RD2, RD3, FIN, WR and DONE.
- IDLE → RD0 when `maxp_en`=1:
  - On this edge, latch `memstartp`, `memstartzap`, `matrix`, `matrix2` and `channels`.
  - Clear the counters `ox`, `oy` and `ch`.
  - If `matrix`<2 or `channels`=0, go directly to DONE with no memory access.
- Output side is O = `matrix`>>1. For an odd `matrix`, the last row and column are dropped.
- Window base address B = `memstartp` + `ch`*`matrix2` + 2*`oy`*`matrix` + 2*`ox`.
  - Read addresses in RD0..RD3: B, B+1, B+`matrix`, B+`matrix`+1.
  - `re`=1 in RD0..RD3 only.
- Data capture and compare:
  - RD1 loads `max` = `qp`.
  - RD2, RD3 and FIN set `max` = signed-greater(`qp`, `max`).
  - On a tie, the earlier value is kept; the result is identical either way.
- In WR: `we`=1, `dp`=`max`, `write_addressp` = `memstartzap` + running write count.
  - The write count increments after each WR.
  - Output is contiguous across channels: channel c starts at `memstartzap` + c*O*O.
- Counter advance after WR:
  - `ox` increments first. It wraps at O and increments `oy`.
  - `oy` wraps at O and increments `ch`.
  - `ch` reaching `channels` → DONE; otherwise → RD0.
- In DONE, `STOP`=1, held until `maxp_en`=0, then → IDLE with `STOP`=0.
- Abort: if `maxp_en`=0 in any RD*/FIN/WR state, go to IDLE next edge.
  - No further `re`/`we` are issued. The pending `qp` is ignored.
- All address sums are modulo 2^ADDR_W and wrap silently.
- Products are computed at ADDR_W width. Inputs above capacity are caller error; no check is made.

## Timing
- All outputs are registered.
- Reset values: `re`=0, `we`=0, `STOP`=0, `read_addressp`=0, `write_addressp`=0, `dp`=0, state=IDLE.
- Edge E0 samples `maxp_en`=1 in IDLE. `re` is high for the 4 cycles following E0.
- Each window takes exactly 6 cycles (RD0..RD3, FIN, WR). There are no bubbles between windows or channels.
- For W = `channels`*O*O windows, `STOP` is first high after edge E0+6W. The final `we` is in the cycle before that.
- Degenerate start (`matrix`<2 or `channels`=0): `STOP` is high after E0+1.
- `read_addressp`/`write_addressp` hold their last value when the strobe is low.
- `dp` holds its last value when `we`=0.
- Input ports are ignored after E0 until the engine returns to IDLE.

## Configuration
- `MAXP_RELU_EN` defined: the WR value is `dp` = (`max`<0) ? 0 : `max`. ReLU is fused at no extra cycle cost.
- `MAXP_RELU_EN` undefined: `dp` = `max`, signed, unmodified.

## Test plan
- Single channel, `matrix`=4, `matrix2`=16, `memstartp`=100, `memstartzap`=500, mem[100+i]=i-8:
  - Writes, in order: -3@500, -1@501, 5@502, 7@503.
  - `STOP` after E0+24.
  - Reads in the first window: 100, 101, 104, 105.
- Same stimulus with `MAXP_RELU_EN` defined: writes 0@500, 0@501, 5@502, 7@503.
- Two channels, `matrix`=5, `matrix2`=25, all pixels equal to their address mod 64:
  - 8 writes at 500..507. Channel 1 reads start at 125.
  - Row 4 and column 4 are never read.
  - `STOP` after E0+48.
- Degenerate starts: `matrix`=1, or `channels`=0.
  - No `re`/`we` pulse; `STOP`=1 after E0+1.
  - `STOP` stays high until `maxp_en`=0, then drops the next cycle.
- Abort and reset:
  - Drop `maxp_en` during the second window's RD2: no further `we`; IDLE next cycle. Re-enabling restarts at window 0.
  - Assert `rst_n`=0 mid-WR: all outputs are 0 immediately, asynchronously.

Source files
------------

// File: rtl/maxpool_engine.sv
// maxpool_engine: 2x2 stride-2 max-pooling over `channels` feature maps held
// back to back in pixel memory; pooled maps are written contiguously.
// Optional feature: define MAXP_RELU_EN to clamp negative results to zero on write.
// Memory handshake: registered re/we, read data on qp one cycle after re.
module maxpool_engine #(
  parameter int unsigned DATA_W = 11,
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned SIDE_W = 5,
  parameter int unsigned SQ_W   = 10,
  parameter int unsigned CH_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     maxp_en,
  input  logic [ADDR_W-1:0]        memstartp,
  input  logic [ADDR_W-1:0]        memstartzap,
  input  logic [SIDE_W-1:0]        matrix,
  input  logic [SQ_W-1:0]          matrix2,
  input  logic [CH_W-1:0]          channels,
  output logic [ADDR_W-1:0]        read_addressp,
  output logic                     re,
  input  logic signed [DATA_W-1:0] qp,
  output logic [ADDR_W-1:0]        write_addressp,
  output logic                     we,
  output logic signed [DATA_W-1:0] dp,
  output logic                     STOP
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StRd0  = 3'd1;
  localparam logic [2:0] StRd1  = 3'd2;
  localparam logic [2:0] StRd2  = 3'd3;
  localparam logic [2:0] StRd3  = 3'd4;
  localparam logic [2:0] StFin  = 3'd5;
  localparam logic [2:0] StWr   = 3'd6;
  localparam logic [2:0] StDone = 3'd7;

  logic [2:0] state_q, state_d;

  // Job parameters latched at start.
  logic [ADDR_W-1:0] zap_q, zap_d;
  logic [ADDR_W-1:0] m_q, m_d;        // map side, widened to address width
  logic [ADDR_W-1:0] m2_q, m2_d;      // per-channel stride
  logic [SIDE_W-1:0] side_q, side_d;  // output side O
  logic [CH_W-1:0]   chans_q, chans_d;

  // Window counters.
  logic [SIDE_W-1:0] ox_q, ox_d;
  logic [SIDE_W-1:0] oy_q, oy_d;
  logic [CH_W-1:0]   ch_q, ch_d;

  // Incrementally maintained addresses: channel base, window-row base, window base.
  logic [ADDR_W-1:0] chan_q, chan_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] win_q, win_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;

  logic signed [DATA_W-1:0] max_q, max_d;

  // Registered outputs.
  logic [ADDR_W-1:0]        raddr_q, raddr_d;
  logic                     re_q, re_d;
  logic [ADDR_W-1:0]        waddr_q, waddr_d;
  logic                     we_q, we_d;
  logic signed [DATA_W-1:0] dp_q, dp_d;
  logic                     stop_q, stop_d;

  logic                     active;
  logic                     last_x, last_y, last_c;
  logic [CH_W-1:0]          ch_inc;
  logic [ADDR_W-1:0]        row_adv, chan_adv;
  logic signed [DATA_W-1:0] max_pick;
  logic signed [DATA_W-1:0] wr_val;

  assign active   = (state_q != StIdle) && (state_q != StDone);
  assign last_x   = (ox_q == side_q - SIDE_W'(1));
  assign last_y   = (oy_q == side_q - SIDE_W'(1));
  assign ch_inc   = ch_q + CH_W'(1);
  assign last_c   = (ch_inc == chans_q);
  assign row_adv  = row_q + (m_q << 1);
  assign chan_adv = chan_q + m2_q;

  // Strict signed compare, so on a tie the earlier pixel is kept.
  assign max_pick = (qp > max_q) ? qp : max_q;

`ifdef MAXP_RELU_EN
  assign wr_val = max_pick[DATA_W-1] ? '0 : max_pick;
`else
  assign wr_val = max_pick;
`endif

  // Next-state, counter and output-register logic.
  always_comb begin
    state_d  = state_q;
    zap_d    = zap_q;
    m_d      = m_q;
    m2_d     = m2_q;
    side_d   = side_q;
    chans_d  = chans_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    ch_d     = ch_q;
    chan_d   = chan_q;
    row_d    = row_q;
    win_d    = win_q;
    wr_cnt_d = wr_cnt_q;
    max_d    = max_q;
    raddr_d  = raddr_q;
    re_d     = 1'b0;
    waddr_d  = waddr_q;
    we_d     = 1'b0;
    dp_d     = dp_q;
    stop_d   = stop_q;

    if (active && !maxp_en) begin
      // Abort: drop back to idle, the in-flight qp is simply never sampled.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          stop_d = 1'b0;
          if (maxp_en) begin
            zap_d    = memstartzap;
            m_d      = ADDR_W'(matrix);
            m2_d     = ADDR_W'(matrix2);
            side_d   = matrix >> 1;
            chans_d  = channels;
            ox_d     = '0;
            oy_d     = '0;
            ch_d     = '0;
            wr_cnt_d = '0;
            chan_d   = memstartp;
            row_d    = memstartp;
            win_d    = memstartp;
            if ((matrix < SIDE_W'(2)) || (channels == '0)) begin
              // STOP rises one cycle after DONE is entered on this path.
              state_d = StDone;
            end else begin
              state_d = StRd0;
              re_d    = 1'b1;
              raddr_d = memstartp;
            end
          end
        end
        StRd0: begin
          state_d = StRd1;
          re_d    = 1'b1;
          raddr_d = win_q + ADDR_W'(1);
        end
        StRd1: begin
          max_d   = qp;
          state_d = StRd2;
          re_d    = 1'b1;
          raddr_d = win_q + m_q;
        end
        StRd2: begin
          max_d   = max_pick;
          state_d = StRd3;
          re_d    = 1'b1;
          raddr_d = win_q + m_q + ADDR_W'(1);
        end
        StRd3: begin
          max_d   = max_pick;
          state_d = StFin;
        end
        StFin: begin
          max_d   = max_pick;
          state_d = StWr;
          we_d    = 1'b1;
          waddr_d = zap_q + wr_cnt_q;
          dp_d    = wr_val;
        end
        StWr: begin
          wr_cnt_d = wr_cnt_q + ADDR_W'(1);
          if (!last_x) begin
            ox_d  = ox_q + SIDE_W'(1);
            win_d = win_q + ADDR_W'(2);
          end else if (!last_y) begin
            ox_d  = '0;
            oy_d  = oy_q + SIDE_W'(1);
            row_d = row_adv;
            win_d = row_adv;
          end else begin
            ox_d   = '0;
            oy_d   = '0;
            ch_d   = ch_inc;
            chan_d = chan_adv;
            row_d  = chan_adv;
            win_d  = chan_adv;
          end
          if (last_x && last_y && last_c) begin
            state_d = StDone;
            stop_d  = 1'b1;
          end else begin
            state_d = StRd0;
            re_d    = 1'b1;
            raddr_d = win_d;
          end
        end
        StDone: begin
          if (maxp_en) begin
            stop_d = 1'b1;
          end else begin
            stop_d  = 1'b0;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM, job parameters, counters and running max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      zap_q    <= '0;
      m_q      <= '0;
      m2_q     <= '0;
      side_q   <= '0;
      chans_q  <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      ch_q     <= '0;
      chan_q   <= '0;
      row_q    <= '0;
      win_q    <= '0;
      wr_cnt_q <= '0;
      max_q    <= '0;
    end else begin
      state_q  <= state_d;
      zap_q    <= zap_d;
      m_q      <= m_d;
      m2_q     <= m2_d;
      side_q   <= side_d;
      chans_q  <= chans_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      ch_q     <= ch_d;
      chan_q   <= chan_d;
      row_q    <= row_d;
      win_q    <= win_d;
      wr_cnt_q <= wr_cnt_d;
      max_q    <= max_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raddr_q <= '0;
      re_q    <= 1'b0;
      waddr_q <= '0;
      we_q    <= 1'b0;
      dp_q    <= '0;
      stop_q  <= 1'b0;
    end else begin
      raddr_q <= raddr_d;
      re_q    <= re_d;
      waddr_q <= waddr_d;
      we_q    <= we_d;
      dp_q    <= dp_d;
      stop_q  <= stop_d;
    end
  end

  assign read_addressp  = raddr_q;
  assign re             = re_q;
  assign write_addressp = waddr_q;
  assign we             = we_q;
  assign dp             = dp_q;
  assign STOP           = stop_q;

endmodule
